// File: rtl/img2col_weight_frontend.sv
// Convolution front end: caches one layer's weight matrix from a 64-bit stream,
// then pairs each img2col feature word with its weight word and frames the output matrix.
module img2col_weight_frontend #(
  parameter int DATA_W  = 64,
  parameter int WADDR_W = 11,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       matrix_row,
  input  logic [15:0]       matrix_col,
  input  logic [31:0]       out_matrix_row,
  input  logic              layer_end,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              weight_cached,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [DATA_W-1:0] f_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] m_weight,
  output logic              m_last,
  output logic              raddr_valid,
  output logic [1:0]        dbg_state
);

  // Handshakes: a word moves on a channel exactly in the cycle where valid && ready
  // are both high at the rising clock edge; a source holds its word until then.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [0:(1<<WADDR_W)-1];

  logic [CNT_W-1:0] ww, total;
  logic [CNT_W-1:0] wcnt, bcnt, raddr;
  logic [CNT_W-1:0] prod, ww_in, pw_in, total_in;
  logic             sizes_ok, start_ok;
  logic             w_acc, f_acc, m_acc, frame_end, last_word;

  always_comb begin
    prod     = CNT_W'(matrix_row) * CNT_W'(matrix_col);
    ww_in    = prod >> 3;
    pw_in    = CNT_W'(matrix_row[15:3]);
    total_in = CNT_W'(out_matrix_row) * pw_in;
  end

  // Zero-sized layers would never complete a load or a frame, so start is ignored.
  assign sizes_ok  = (ww_in != '0) && (total_in != '0);
  assign start_ok  = start && sizes_ok;

  assign w_acc     = w_valid && w_ready;
  assign f_acc     = f_valid && f_ready;
  assign m_acc     = m_valid && m_ready;
  assign frame_end = m_acc && m_last;
  assign last_word = w_acc && (wcnt == ww - CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start_ok) state_nxt = S_LOAD;
      S_LOAD: begin
        if (start_ok)       state_nxt = S_LOAD;
        else if (last_word) state_nxt = S_RUN;
      end
      S_RUN:  if (frame_end && layer_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; the final beat's handoff cycle blocks new features so frames never merge.
  always_comb begin
    w_ready     = (state == S_LOAD) && !start_ok;
    f_ready     = (state == S_RUN) && weight_cached && (!m_valid || m_ready) && !frame_end;
    raddr_valid = m_acc;
    dbg_state   = state;
  end

  always_ff @(posedge clk) begin
    if (w_acc) mem[wcnt[WADDR_W-1:0]] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ww            <= '0;
      total         <= '0;
      wcnt          <= '0;
      bcnt          <= '0;
      raddr         <= '0;
      weight_cached <= 1'b0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      m_data        <= '0;
      m_weight      <= '0;
    end else begin
      if (start_ok && (state != S_RUN)) begin
        ww    <= ww_in;
        total <= total_in;
        wcnt  <= '0;
        bcnt  <= '0;
        raddr <= '0;
      end else if (w_acc) begin
        wcnt <= wcnt + CNT_W'(1);
      end

      if (last_word && !start_ok)         weight_cached <= 1'b1;
      else if (frame_end && layer_end)    weight_cached <= 1'b0;

      if (f_acc) begin
        m_data   <= f_data;
        m_weight <= mem[raddr[WADDR_W-1:0]];
        m_valid  <= 1'b1;
        m_last   <= (bcnt == total - CNT_W'(1));
        bcnt     <= bcnt + CNT_W'(1);
        raddr    <= (raddr == ww - CNT_W'(1)) ? '0 : raddr + CNT_W'(1);
      end else if (m_acc) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      if (frame_end) begin
        bcnt  <= '0;
        raddr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_img2col_weight_frontend.sv
// Randomised bench for img2col_weight_frontend: a cache/frame reference model feeds
// an expected queue that an independent output monitor drains and compares.
module tb_img2col_weight_frontend;

  localparam int DW = 64;
  localparam int EW = 2 * DW + 1;

  logic          clk, reset, start;
  logic [15:0]   matrix_row, matrix_col;
  logic [31:0]   out_matrix_row;
  logic          layer_end;
  logic          w_valid, w_ready;
  logic [DW-1:0] w_data;
  logic          weight_cached;
  logic          f_valid, f_ready;
  logic [DW-1:0] f_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data, m_weight;
  logic          m_last, raddr_valid;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [DW-1:0] ref_cache [0:2047];

  int  checks, errors;
  int  rdy_mode;
  bit  mon_en;
  int  lasts;

  img2col_weight_frontend dut (
    .clk(clk), .reset(reset), .start(start),
    .matrix_row(matrix_row), .matrix_col(matrix_col), .out_matrix_row(out_matrix_row),
    .layer_end(layer_end),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .weight_cached(weight_cached),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_weight(m_weight),
    .m_last(m_last), .raddr_valid(raddr_valid), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Output back-pressure driver
  always @(negedge clk) begin
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = !m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every accepted output beat
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      check("raddr_valid", DW'(raddr_valid), DW'(m_valid && m_ready));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none t=%0t", m_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("m_data", m_data, mon_e[DW-1:0]);
          check("m_weight", m_weight, mon_e[2*DW-1:DW]);
          check("m_last", DW'(m_last), DW'(mon_e[EW-1]));
          if (m_last) begin
            lasts++;
            check("f_ready_at_frame_end", DW'(f_ready), '0);
          end
        end
      end
    end
  end

  // Load driver with reference cache; optional restart and reset abort points
  task automatic load_weights(input int mr, input int mc, input int omr,
                              input int restart_at, input int abort_at, input bit gaps);
    int idx, ww, budget;
    bit restarted;
    ww = mr * mc / 8;
    @(negedge clk);
    matrix_row = 16'(mr); matrix_col = 16'(mc); out_matrix_row = 32'(omr);
    start = 1'b1; w_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; budget = 0; restarted = 0;
    while (idx < ww && budget < 20000) begin
      w_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      w_data  = {$urandom, $urandom};
      if (!restarted && restart_at > 0 && idx == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      #1;
      check("f_ready_during_load", DW'(f_ready), '0);
      check("cached_during_load", DW'(weight_cached), '0);
      if (abort_at >= 0 && idx == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_w_ready", DW'(w_ready), '0);
        check("abort_cached", DW'(weight_cached), '0);
        check("abort_m_valid", DW'(m_valid), '0);
        check("abort_f_ready", DW'(f_ready), '0);
        @(negedge clk);
        reset = 1'b0; w_valid = 1'b0;
        return;
      end
      if (start) begin
        check("w_ready_on_restart", DW'(w_ready), '0);
        idx = 0;
      end else if (w_valid && w_ready) begin
        ref_cache[idx] = w_data;
        idx++;
      end
      @(negedge clk);
      start = 1'b0;
      budget++;
    end
    if (idx < ww) begin
      checks++; errors++;
      $display("FAIL load_timeout actual=%0d required=%0d", idx, ww);
    end
    w_valid = 1'b1;
    #1;
    check("cached_after_last_word", DW'(weight_cached), 1);
    check("no_extra_word", DW'(w_ready), '0);
    w_valid = 1'b0;
  endtask

  // Feature driver: pushes the expected paired beat as each feature word is accepted
  task automatic run_frame(input int total, input int ww, input bit le, input bit dense);
    int k, budget, lasts0;
    k = 0; budget = 0; lasts0 = lasts;
    layer_end = le;
    while (k < total && budget < 50000) begin
      @(negedge clk);
      f_valid = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
      f_data  = {$urandom, $urandom};
      #1;
      if (f_valid && f_ready) begin
        exp_q.push_back({(k == total - 1), ref_cache[k % ww], f_data});
        k++;
      end
      budget++;
    end
    @(negedge clk);
    f_valid = 1'b0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (k < total || exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout actual=%0d required=%0d pending=%0d", k, total, exp_q.size());
      exp_q.delete();
    end
    #3;
    check("frame_last_count", DW'(lasts - lasts0), 1);
    check("cached_after_frame", DW'(weight_cached), DW'(!le));
    if (le) begin
      f_valid = 1'b1;
      #1;
      check("f_ready_after_layer_end", DW'(f_ready), '0);
      f_valid = 1'b0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; lasts = 0; mon_en = 0; rdy_mode = 0;
    reset = 1'b1; start = 1'b0; layer_end = 1'b0;
    matrix_row = '0; matrix_col = '0; out_matrix_row = '0;
    w_valid = 1'b0; w_data = '0; f_valid = 1'b0; f_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", DW'(m_valid), '0);
    check("rst_m_last", DW'(m_last), '0);
    check("rst_w_ready", DW'(w_ready), '0);
    check("rst_f_ready", DW'(f_ready), '0);
    check("rst_cached", DW'(weight_cached), '0);
    check("rst_raddr_valid", DW'(raddr_valid), '0);
    check("rst_m_data", m_data, '0);
    reset = 1'b0;
    mon_en = 1;

    // Full-size layer, raddr wraps inside the frame, two frames then release
    load_weights(288, 32, 40, -1, -1, 0);
    rdy_mode = 2;
    run_frame(1440, 1152, 0, 0);
    run_frame(1440, 1152, 1, 0);

    // Small layer with toggling back-pressure
    load_weights(16, 8, 3, -1, -1, 1);
    rdy_mode = 1;
    run_frame(6, 16, 0, 1);
    run_frame(6, 16, 1, 1);

    // Frame length not a multiple of the weight count
    load_weights(16, 2, 3, -1, -1, 0);
    rdy_mode = 2;
    run_frame(6, 4, 0, 0);
    run_frame(6, 4, 0, 1);
    run_frame(6, 4, 1, 0);

    // Reset abort at word 500, then a clean reload
    rdy_mode = 0;
    load_weights(288, 32, 2, -1, 500, 0);
    load_weights(288, 32, 2, -1, -1, 0);
    run_frame(72, 1152, 1, 1);

    // Restart pulse at word 10
    rdy_mode = 2;
    load_weights(288, 32, 2, 10, -1, 1);
    run_frame(72, 1152, 1, 0);

    // Degenerate sizes keep the block idle
    @(negedge clk);
    matrix_row = 16'd0; matrix_col = 16'd8; out_matrix_row = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; w_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("zero_ww_idle", DW'(w_ready), '0);
    @(negedge clk);
    matrix_row = 16'd16; out_matrix_row = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("zero_total_idle", DW'(w_ready), '0);
    check("zero_total_cached", DW'(weight_cached), '0);
    w_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
